mdu_iter: RTL
=============

Name: mdu_iter

Overview:
- Iterative RV64M multiply/divide unit for the NPC execute stage. It sits beside the combinational alu.
- Takes one operation at a time over a valid/ready handshake and computes one product or quotient bit per cycle.
- Returns the result over a second valid/ready handshake.
- Supports RV64M word (*W) variants, divide-by-zero and signed-overflow special cases, and pipeline flush.

Parameters:
- WIDTH, 64, datapath width (= CPU_WIDTH); must be even and ≥ 8.
- HALF, WIDTH/2, word-variant width (32 for RV64).
- OPT_WIDTH, 3, width of the operation code.

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_flush  in  1  synchronous abort of any in-flight operation.
- i_valid  in  1  request valid.
- o_ready  out  1  unit can accept a request (state IDLE).
- i_opt  in  OPT_WIDTH  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- i_word  in  1  word variant; meaningful for MUL/DIV/DIVU/REM/REMU, ignored for MULH*.
- i_src1  in  WIDTH  rs1 operand (multiplicand / dividend).
- i_src2  in  WIDTH  rs2 operand (multiplier / divisor).
- o_valid  out  1  result valid (state DONE).
- i_ready  in  1  consumer takes result.
- o_res  out  WIDTH  result.
- o_busy  out  1  state is CALC or DONE.

Behaviour:
- Reset: state IDLE; o_ready=1, o_valid=0, o_busy=0, o_res=0, all internal registers 0.
- States: IDLE, CALC, DONE.
- IDLE→CALC: on i_valid && o_ready. Operands, opcode and word flag are latched at this edge; later input changes are ignored.
- IDLE→DONE directly (special cases, o_valid one cycle after accept):
  - divide by zero: quotient = all ones; remainder = dividend.
  - signed overflow (DIV/REM, dividend = most-negative, divisor = −1): quotient = dividend; remainder = 0.
  - Both checks use the effective width (HALF when word).
- CALC: down-counter loaded with N = HALF (word) or WIDTH.
  - Each cycle performs one shift-add (multiply) or one restoring subtract-shift (divide) step.
  - When the counter reaches 0, sign correction is applied and the FSM moves to DONE.
  - Latency: o_valid asserts exactly N+1 cycles after the accept edge (65 for 64-bit ops, 33 for word ops).
- DONE: o_valid=1 and o_res stable until i_valid... rather, until i_ready is high at an edge, then →IDLE. o_ready stays 0 in DONE, so no back-to-back accept in the same cycle.
- Operand preparation:
  - Signed operands are converted to magnitude. The sign of each source follows the op: MULHSU treats src1 as signed, src2 as unsigned.
  - Word mode: take the low HALF bits, sign-extend for signed ops and zero-extend for unsigned ops before the magnitude step.
- Result selection:
  - MUL: low WIDTH bits of the product.
  - MULH, MULHSU, MULHU: high WIDTH bits of the product.
  - Negate the product when the operand signs differ.
  - Quotient sign = s1 ^ s2. Remainder sign = sign of the dividend.
  - Word mode: result = sign-extended low HALF bits, including DIVUW/REMUW.
- Flush: i_flush at an edge forces IDLE from any state and drops o_valid. It has priority over i_valid/i_ready in the same cycle; a request presented with i_flush is not accepted.
- Reset mid-operation behaves like flush and also clears o_res.
- Counter and product registers never wrap. The product accumulator is 2·WIDTH bits; the remainder register is WIDTH+1 bits.

Decomposition:
- Shared defines/package, next to the ALU codes:
  - MDU_OPT_WIDTH and the eight MDU op codes;
  - state encodings (2 bits);
  - the helper predicate for signed ops.
- One sub-module, mdu_div_step: combinational single restoring-division step. Inputs: partial remainder, dividend bit, divisor. Outputs: next remainder and quotient bit.
- The multiply step is inline.

Test Plan:
- MUL 7×(−3), word=0, i_ready=1 → o_valid 65 cycles after accept; o_res = 0xFFFF_FFFF_FFFF_FFEB.
- MULHU 0xFFFF_FFFF_FFFF_FFFF × same → o_res = 0xFFFF_FFFF_FFFF_FFFE. MULHSU (−1)×2 → o_res = all ones.
- DIV (−7)/2 → 0xFFFF_FFFF_FFFF_FFFD. REM (−7)/2 → all ones (−1). DIVUW 0x1_8000_0000 / 1 → 0xFFFF_FFFF_8000_0000, latency 33.
- DIVU x/0 → all ones, latency 1. REM 5/0 → 5. DIV 0x8000_0000_0000_0000 / −1 → same value. REMW 0x8000_0000 / −1 → 0.
- Backpressure: hold i_ready=0 for 10 cycles in DONE → o_valid and o_res stable, o_ready=0. On i_ready, IDLE next cycle; the next request is accepted on the following edge.
- Flush at CALC cycle 20, and i_rst asserted at cycle 5 of a second op → IDLE next edge, o_valid never asserts; a subsequent MUL 3×4 returns 12.

Source files
------------

// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative RV64M multiply/divide unit.
// Contents: op-code width and codes, FSM state encoding, and op-classification helpers.
// Latency/backpressure: not applicable (types and pure functions only).
package mdu_iter_pkg;

   localparam int MDU_OPT_WIDTH = 3;

   typedef enum logic [MDU_OPT_WIDTH-1:0] {
      MDU_MUL    = 3'd0,
      MDU_MULH   = 3'd1,
      MDU_MULHSU = 3'd2,
      MDU_MULHU  = 3'd3,
      MDU_DIV    = 3'd4,
      MDU_DIVU   = 3'd5,
      MDU_REM    = 3'd6,
      MDU_REMU   = 3'd7
   } mdu_op_e;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'd0,
      MDU_CALC = 2'd1,
      MDU_DONE = 2'd2
   } mdu_state_e;

   // MUL is treated as signed on both sides; its low product bits do not
   // depend on signedness, and this keeps the word variant sign-extending.
   function automatic logic mdu_src1_signed(input mdu_op_e op);
      return op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
   endfunction

   function automatic logic mdu_src2_signed(input mdu_op_e op);
      return op inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
   endfunction

   function automatic logic mdu_is_div(input mdu_op_e op);
      return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
   endfunction

   function automatic logic mdu_is_rem(input mdu_op_e op);
      return op inside {MDU_REM, MDU_REMU};
   endfunction

   function automatic logic mdu_is_mulh(input mdu_op_e op);
      return op inside {MDU_MULH, MDU_MULHSU, MDU_MULHU};
   endfunction

endpackage

// File: rtl/mdu_iter_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
// Ports: i_rem partial remainder, i_bit next dividend bit, i_dsr divisor magnitude -> o_rem, o_qbit.
// Latency: combinational; backpressure: none.
module mdu_div_step #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH:0]   i_rem,
   input  logic             i_bit,
   input  logic [WIDTH-1:0] i_dsr,
   output logic [WIDTH:0]   o_rem,
   output logic             o_qbit
);

   logic [WIDTH:0]   w_shift;
   logic [WIDTH+1:0] w_diff;

   // The partial remainder is always below the divisor, so the shifted
   // value fits in WIDTH+1 bits; the extra diff bit is the borrow.
   assign w_shift = {i_rem[WIDTH-1:0], i_bit};
   assign w_diff  = {1'b0, w_shift} - {2'b00, i_dsr};

   // i_rem[WIDTH] is never set by a restoring divider; if it were, the
   // shifted value would certainly exceed the divisor.
   assign o_qbit = i_rem[WIDTH] | ~w_diff[WIDTH+1];
   assign o_rem  = o_qbit ? w_diff[WIDTH:0] : w_shift;

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit: one product/quotient bit per cycle, with *W variants.
// Ports: i_valid/o_ready request (i_opt, i_word, i_src1, i_src2); o_valid/i_ready result (o_res); i_flush abort; o_busy.
// Latency N+1 cycles from accept (N = HALF for word ops, else WIDTH), 1 cycle for div-by-zero/overflow; result held until i_ready.
module mdu_iter
   import mdu_iter_pkg::*;
#(
   parameter int WIDTH     = 64,
   parameter int HALF      = WIDTH / 2,
   parameter int OPT_WIDTH = MDU_OPT_WIDTH
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_flush,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [OPT_WIDTH-1:0] i_opt,
   input  logic                 i_word,
   input  logic [WIDTH-1:0]     i_src1,
   input  logic [WIDTH-1:0]     i_src2,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [WIDTH-1:0]     o_res,
   output logic                 o_busy
);

   localparam int CW = $clog2(WIDTH + 1);

   // state and datapath registers
   mdu_state_e         r_state;
   mdu_op_e            r_op;
   logic               r_word;
   logic               r_neg1;
   logic               r_neg2;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_opa;     // multiplier (shifts right) or dividend/quotient (shifts left)
   logic [WIDTH-1:0]   r_dsr;
   logic [WIDTH:0]     r_rem;
   logic [WIDTH-1:0]   r_res;

   // accept-side decode
   mdu_state_e         w_state_nxt;
   mdu_op_e            w_op;
   logic               w_word;
   logic [WIDTH-1:0]   w_ext1;
   logic [WIDTH-1:0]   w_ext2;
   logic               w_neg1;
   logic               w_neg2;
   logic [WIDTH-1:0]   w_mag1;
   logic [WIDTH-1:0]   w_mag2;
   logic [WIDTH-1:0]   w_min_neg;
   logic               w_div_zero;
   logic               w_div_ovf;
   logic [WIDTH-1:0]   w_spec;
   logic [WIDTH-1:0]   w_spec_res;

   // iteration and result
   logic               w_accept;
   logic               w_step;
   logic               w_last;
   logic [WIDTH:0]     w_rem_nxt;
   logic               w_qbit;
   logic [2*WIDTH-1:0] w_acc_nxt;
   logic [WIDTH-1:0]   w_opa_nxt;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rmd;
   logic [WIDTH-1:0]   w_sel;
   logic [WIDTH-1:0]   w_fin_res;

   // Operand preparation: word extension, sign detection, magnitudes and
   // the two division special cases, all evaluated at the effective width.
   always_comb begin
      w_op   = mdu_op_e'(i_opt);
      w_word = i_word && !mdu_is_mulh(w_op);
      w_ext1 = i_src1;
      w_ext2 = i_src2;
      if (w_word) begin
         w_ext1 = {{(WIDTH-HALF){mdu_src1_signed(w_op) & i_src1[HALF-1]}}, i_src1[HALF-1:0]};
         w_ext2 = {{(WIDTH-HALF){mdu_src2_signed(w_op) & i_src2[HALF-1]}}, i_src2[HALF-1:0]};
      end
      w_neg1 = mdu_src1_signed(w_op) & w_ext1[WIDTH-1];
      w_neg2 = mdu_src2_signed(w_op) & w_ext2[WIDTH-1];
      w_mag1 = w_neg1 ? -w_ext1 : w_ext1;
      w_mag2 = w_neg2 ? -w_ext2 : w_ext2;

      // most-negative value of the effective width, as seen after sign extension
      w_min_neg = w_word ? {{(WIDTH-HALF+1){1'b1}}, {(HALF-1){1'b0}}}
                         : {1'b1, {(WIDTH-1){1'b0}}};
      w_div_zero = mdu_is_div(w_op) && (w_ext2 == '0);
      w_div_ovf  = (w_op == MDU_DIV || w_op == MDU_REM)
                && (w_ext1 == w_min_neg) && (w_ext2 == '1);

      if (w_div_zero) begin
         w_spec = mdu_is_rem(w_op) ? w_ext1 : '1;
      end else begin
         w_spec = mdu_is_rem(w_op) ? '0 : w_ext1;
      end
      w_spec_res = w_word ? {{(WIDTH-HALF){w_spec[HALF-1]}}, w_spec[HALF-1:0]} : w_spec;
   end

   mdu_div_step #(
      .WIDTH (WIDTH)
   ) u_div_step (
      .i_rem  (r_rem),
      .i_bit  (r_opa[WIDTH-1]),
      .i_dsr  (r_dsr),
      .o_rem  (w_rem_nxt),
      .o_qbit (w_qbit)
   );

   // One iteration, plus sign correction applied to the post-step values so
   // the final step and the result write share the same edge.
   always_comb begin
      w_acc_nxt = r_opa[0] ? (r_acc + r_mcand) : r_acc;
      w_opa_nxt = mdu_is_div(r_op) ? {r_opa[WIDTH-2:0], w_qbit}
                                   : {1'b0, r_opa[WIDTH-1:1]};
      w_prod = (r_neg1 ^ r_neg2) ? -w_acc_nxt : w_acc_nxt;
      w_quo  = (r_neg1 ^ r_neg2) ? -w_opa_nxt : w_opa_nxt;
      w_rmd  = r_neg1 ? -w_rem_nxt[WIDTH-1:0] : w_rem_nxt[WIDTH-1:0];

      case (r_op)
         MDU_MUL:                        w_sel = w_prod[WIDTH-1:0];
         MDU_MULH, MDU_MULHSU, MDU_MULHU: w_sel = w_prod[2*WIDTH-1:WIDTH];
         MDU_DIV, MDU_DIVU:              w_sel = w_quo;
         MDU_REM, MDU_REMU:              w_sel = w_rmd;
         default:                        w_sel = w_prod[WIDTH-1:0];
      endcase
      w_fin_res = r_word ? {{(WIDTH-HALF){w_sel[HALF-1]}}, w_sel[HALF-1:0]} : w_sel;
   end

   // FSM next state; flush overrides every other transition.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_step      = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         MDU_IDLE: begin
            if (i_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = (w_div_zero || w_div_ovf) ? MDU_DONE : MDU_CALC;
            end
         end
         MDU_CALC: begin
            w_step = (r_cnt != '0);
            w_last = (r_cnt == CW'(1));
            if (r_cnt <= CW'(1)) begin
               w_state_nxt = MDU_DONE;
            end
         end
         MDU_DONE: begin
            if (i_ready) begin
               w_state_nxt = MDU_IDLE;
            end
         end
         default: w_state_nxt = MDU_IDLE;
      endcase
      if (i_flush) begin
         w_state_nxt = MDU_IDLE;
         w_accept    = 1'b0;
         w_step      = 1'b0;
         w_last      = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= MDU_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_op    <= MDU_MUL;
         r_word  <= 1'b0;
         r_neg1  <= 1'b0;
         r_neg2  <= 1'b0;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_mcand <= '0;
         r_opa   <= '0;
         r_dsr   <= '0;
         r_rem   <= '0;
         r_res   <= '0;
      end else if (w_accept) begin
         r_op    <= w_op;
         r_word  <= w_word;
         r_neg1  <= w_neg1;
         r_neg2  <= w_neg2;
         r_cnt   <= w_word ? CW'(HALF) : CW'(WIDTH);
         r_acc   <= '0;
         r_rem   <= '0;
         r_mcand <= {{WIDTH{1'b0}}, w_mag1};
         r_dsr   <= w_mag2;
         if (mdu_is_div(w_op)) begin
            // word dividends are pre-aligned so the first step sees their MSB
            r_opa <= w_word ? (w_mag1 << HALF) : w_mag1;
         end else begin
            r_opa <= w_mag2;
         end
         if (w_div_zero || w_div_ovf) begin
            r_res <= w_spec_res;
         end
      end else if (w_step) begin
         r_cnt <= r_cnt - 1'b1;
         r_opa <= w_opa_nxt;
         if (mdu_is_div(r_op)) begin
            r_rem <= w_rem_nxt;
         end else begin
            r_acc   <= w_acc_nxt;
            r_mcand <= r_mcand << 1;
         end
         if (w_last) begin
            r_res <= w_fin_res;
         end
      end
   end

   assign o_ready = (r_state == MDU_IDLE);
   assign o_valid = (r_state == MDU_DONE);
   assign o_busy  = (r_state == MDU_CALC) || (r_state == MDU_DONE);
   assign o_res   = r_res;

endmodule
